// File: rtl/adder_result_accumulator.sv
// Accumulates blocks of 9-bit adder results into a wide total.
// Emits one total per block over a valid/ready output stream.
module adder_result_accumulator #(
  parameter int BLOCK_LEN = 4,
  parameter int ACC_WIDTH = 16,
  localparam int CW = $clog2(BLOCK_LEN + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_carry,
  input  logic [7:0]           in_sum,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_data,
  output logic [CW-1:0]        out_count,
  output logic                 out_overflow
);

  localparam logic [0:0] ACCUM = 1'b0;
  localparam logic [0:0] HOLD  = 1'b1;

  logic [0:0]           state;
  logic [ACC_WIDTH-1:0] acc;
  logic [CW-1:0]        cnt;
  logic                 ovf;

  logic                 accept;
  logic                 close;
  logic [ACC_WIDTH-1:0] addend;
  logic [ACC_WIDTH:0]   add_full;
  logic [ACC_WIDTH-1:0] nxt_acc;
  logic [CW-1:0]        nxt_cnt;
  logic                 nxt_ovf;

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == HOLD);

  assign accept   = in_valid && in_ready;
  assign addend   = ACC_WIDTH'({in_carry, in_sum});
  assign add_full = {1'b0, acc} + {1'b0, addend};

  // Next values include the current beat so a closing beat lands in the total
  always_comb begin
    nxt_acc = acc;
    nxt_cnt = cnt;
    nxt_ovf = ovf;
    if (accept) begin
      nxt_acc = add_full[ACC_WIDTH-1:0];
      nxt_cnt = cnt + CW'(1);
      nxt_ovf = ovf | add_full[ACC_WIDTH];
    end
  end

  always_comb begin
    close = 1'b0;
    if (state == ACCUM) begin
      close = (accept && (cnt == CW'(BLOCK_LEN - 1)))
           || (flush && ((cnt != '0) || accept));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ACCUM;
      acc          <= '0;
      cnt          <= '0;
      ovf          <= 1'b0;
      out_data     <= '0;
      out_count    <= '0;
      out_overflow <= 1'b0;
    end else begin
      if (close) begin
        out_data     <= nxt_acc;
        out_count    <= nxt_cnt;
        out_overflow <= nxt_ovf;
        acc          <= '0;
        cnt          <= '0;
        ovf          <= 1'b0;
        state        <= HOLD;
      end else if (accept) begin
        acc <= nxt_acc;
        cnt <= nxt_cnt;
        ovf <= nxt_ovf;
      end else if ((state == HOLD) && out_ready) begin
        state <= ACCUM;
      end
    end
  end

endmodule

// File: tb/tb_adder_result_accumulator.sv
// Directed bench for adder_result_accumulator.
// Runs a 16-bit and a 9-bit accumulator side by side on shared stimulus.
module tb_adder_result_accumulator;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_carry = 1'b0;
  logic [7:0] in_sum = '0;
  logic       flush = 1'b0;
  logic       out_ready = 1'b1;

  logic        in_ready, out_valid, out_overflow;
  logic [15:0] out_data;
  logic [2:0]  out_count;
  logic        in_ready9, out_valid9, out_overflow9;
  logic [8:0]  out_data9;
  logic [2:0]  out_count9;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  adder_result_accumulator #(.BLOCK_LEN(4), .ACC_WIDTH(16)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_carry(in_carry), .in_sum(in_sum), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_count(out_count),
    .out_overflow(out_overflow)
  );

  adder_result_accumulator #(.BLOCK_LEN(4), .ACC_WIDTH(9)) u_dut9 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready9),
    .in_carry(in_carry), .in_sum(in_sum), .flush(flush),
    .out_valid(out_valid9), .out_ready(out_ready),
    .out_data(out_data9), .out_count(out_count9),
    .out_overflow(out_overflow9)
  );

  typedef struct {
    int              n;
    logic [3:0][8:0] b;
    bit              fl_last;
    bit              fl_sep;
    logic [15:0]     d16;
    logic [8:0]      d9;
    logic [2:0]      cnt;
    bit              o16;
    bit              o9;
  } vec_t;

  vec_t vecs [7];
  int   nvec = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add_vec(input int n, input logic [8:0] b0, b1, b2, b3,
                         input bit fl_last, fl_sep,
                         input logic [15:0] d16, input logic [8:0] d9,
                         input logic [2:0] cnt, input bit o16, o9);
    vecs[nvec].n       = n;
    vecs[nvec].b       = {b3, b2, b1, b0};
    vecs[nvec].fl_last = fl_last;
    vecs[nvec].fl_sep  = fl_sep;
    vecs[nvec].d16     = d16;
    vecs[nvec].d9      = d9;
    vecs[nvec].cnt     = cnt;
    vecs[nvec].o16     = o16;
    vecs[nvec].o9      = o9;
    nvec++;
  endtask

  task automatic drive_beat(input logic [8:0] v);
    in_valid = 1'b1;
    {in_carry, in_sum} = v;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_valid"}, out_valid, 0);
    chk({nm, "_ready"}, in_ready, 1);
    chk({nm, "_data"}, out_data, 0);
    chk({nm, "_count"}, out_count, 0);
    chk({nm, "_ovf"}, out_overflow, 0);
  endtask

  initial begin
    add_vec(4, 9'h0FF, 9'h100, 9'h001, 9'h1FF, 0, 0,
            16'h03FF, 9'h1FF, 3'd4, 0, 1);
    add_vec(2, 9'h010, 9'h020, 9'h000, 9'h000, 0, 1,
            16'h0030, 9'h030, 3'd2, 0, 0);
    add_vec(3, 9'h010, 9'h020, 9'h005, 9'h000, 1, 0,
            16'h0035, 9'h035, 3'd3, 0, 0);
    add_vec(4, 9'h007, 9'h007, 9'h007, 9'h007, 0, 0,
            16'h001C, 9'h01C, 3'd4, 0, 0);
    add_vec(4, 9'h1FF, 9'h1FF, 9'h1FF, 9'h1FF, 0, 0,
            16'h07FC, 9'h1FC, 3'd4, 0, 1);
    add_vec(2, 9'h1FF, 9'h1FF, 9'h000, 9'h000, 0, 1,
            16'h03FE, 9'h1FE, 3'd2, 0, 1);
    add_vec(4, 9'h001, 9'h001, 9'h001, 9'h001, 0, 0,
            16'h0004, 9'h004, 3'd4, 0, 0);

    #2;
    chk_reset_vals("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // flush with nothing accumulated must not produce a block
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush0_valid", out_valid, 0);
    @(negedge clk);
    chk("flush0_valid2", out_valid, 0);
    chk("flush0_ready", in_ready, 1);

    for (int v = 0; v < nvec; v++) begin
      for (int i = 0; i < vecs[v].n; i++) begin
        chk("vec_ready", in_ready, 1);
        drive_beat(vecs[v].b[i]);
        flush = vecs[v].fl_last && (i == vecs[v].n - 1);
        @(negedge clk);
        if (i < vecs[v].n - 1)
          chk("vec_early_valid", out_valid, 0);
      end
      idle();
      if (vecs[v].fl_sep) begin
        chk("vec_pre_flush_valid", out_valid, 0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
      end
      chk("vec_valid", out_valid, 1);
      chk("vec_ready_low", in_ready, 0);
      chk("vec_data", out_data, vecs[v].d16);
      chk("vec_count", out_count, vecs[v].cnt);
      chk("vec_ovf", out_overflow, vecs[v].o16);
      chk("vec9_data", out_data9, vecs[v].d9);
      chk("vec9_count", out_count9, vecs[v].cnt);
      chk("vec9_ovf", out_overflow9, vecs[v].o9);
      @(negedge clk);
      chk("vec_valid_drop", out_valid, 0);
      chk("vec_ready_back", in_ready, 1);
    end

    // backpressure: block held while downstream stalls
    out_ready = 1'b0;
    drive_beat(9'h0FF); @(negedge clk);
    drive_beat(9'h100); @(negedge clk);
    drive_beat(9'h001); @(negedge clk);
    drive_beat(9'h1FF); @(negedge clk);
    drive_beat(9'h007);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", out_valid, 1);
      chk("bp_ready", in_ready, 0);
      chk("bp_data", out_data, 16'h03FF);
      chk("bp_count", out_count, 3'd4);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", out_valid, 0);
    chk("bp_release_ready", in_ready, 1);
    repeat (4) @(negedge clk);
    idle();
    chk("bp_next_valid", out_valid, 1);
    chk("bp_next_data", out_data, 16'h001C);
    chk("bp_next_count", out_count, 3'd4);
    @(negedge clk);

    // reset mid-block discards the partial sum
    repeat (3) begin
      drive_beat(9'h0AA);
      @(negedge clk);
    end
    idle();
    rst_n = 1'b0;
    #1;
    chk_reset_vals("rst_mid");
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    repeat (4) begin
      drive_beat(9'h001);
      @(negedge clk);
    end
    idle();
    chk("rst_mid_valid", out_valid, 1);
    chk("rst_mid_data", out_data, 16'h0004);
    chk("rst_mid_count", out_count, 3'd4);
    @(negedge clk);

    // reset while a result is pending drops it
    out_ready = 1'b0;
    drive_beat(9'h011); @(negedge clk);
    drive_beat(9'h022); flush = 1'b1; @(negedge clk);
    idle();
    chk("rst_hold_pre", out_valid, 1);
    chk("rst_hold_pre_data", out_data, 16'h0033);
    rst_n = 1'b0;
    #1;
    chk("rst_hold_valid", out_valid, 0);
    chk("rst_hold_ready", in_ready, 1);
    #2;
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_hold_never", out_valid, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/adder_result_accumulator.md
# adder_result_accumulator

Sequential stage directly downstream of the 8-bit adder. Consumes the adder's 9-bit result (carry out plus 8-bit sum) over a valid/ready stream and accumulates a block of `BLOCK_LEN` results into a wider register. It emits one block total per handshake on its output, with the beat count and a sticky overflow flag. A `flush` input closes a partial block early.

## Interface
Parameters:
- `BLOCK_LEN`, default 4: results per full block; legal range ≥1.
- `ACC_WIDTH`, default 16: accumulator/output width; legal range ≥9.
- `CW`, derived as `$clog2(BLOCK_LEN+1)`: count width. Not overridable.

Ports (clock and reset first):
- `clk` input 1: sole clock; all state updates on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset. Assertion takes effect immediately; deassertion is synchronous to `clk` upstream.
- `in_valid` input 1: upstream result valid.
- `in_ready` output 1: block accepts a result this cycle.
- `in_carry` input 1: adder carry out, bit 8 of the addend.
- `in_sum` input 8: adder sum, bits 7:0 of the addend.
- `flush` input 1: close the current partial block.
- `out_valid` output 1: block result available.
- `out_ready` input 1: downstream accepts the result.
- `out_data` output ACC_WIDTH: block total, modulo 2^ACC_WIDTH.
- `out_count` output CW: number of addends in the block.
- `out_overflow` output 1: total exceeded 2^ACC_WIDTH−1.

## Operation
- Addend is `{in_carry, in_sum}`, zero-extended to ACC_WIDTH (range 0..511).
- The FSM has two states, ACCUM and HOLD. Reset state is ACCUM.
- `in_ready` = (state == ACCUM). `out_valid` = (state == HOLD). Both are decoded from registered state only.
- **ACCUM, accept** (`in_valid && in_ready`):
  - acc ← acc + addend; cnt ← cnt + 1.
  - Carry out of the ACC_WIDTH-bit add sets sticky ovf.
- **Block close**, either condition:
  - an accept with cnt == BLOCK_LEN−1 (full block), or
  - `flush` high with (cnt > 0 or an accept this cycle).
- **On close:**
  - load `out_data`/`out_count`/`out_overflow` with the updated acc, cnt and ovf, including this cycle's beat;
  - clear the internal acc, cnt and ovf;
  - state ← HOLD.
- **Flush cases:**
  - `flush` with cnt == 0 and no accept: ignored, no output.
  - `flush` while in HOLD: ignored.
- **HOLD:** `out_*` are held stable until `out_ready`. On `out_valid && out_ready`, state ← ACCUM. Output registers keep their last value; only `out_valid` qualifies them.
- **Overflow:** `out_data` wraps modulo 2^ACC_WIDTH. `out_overflow` = 1 if any add in the block wrapped.
- **Reset mid-operation:** partial accumulation and any pending output are discarded, with no output for them.

## Timing
- **Reset values:** `out_valid` 0, `out_data` 0, `out_count` 0, `out_overflow` 0, `in_ready` 1, state ACCUM, acc/cnt/ovf 0.
- **Latency:** `out_valid` rises the cycle after the closing beat or flush edge (1 cycle).
- **Throughput:**
  - one addend per cycle within a block;
  - HOLD lasts ≥1 cycle, so a full block needs ≥BLOCK_LEN+1 cycles;
  - no input accepted while HOLD is pending.
- **Combinational paths:** no path from `out_ready` to `in_ready`, or from `in_valid` to `out_valid`.
- **Backpressure:** `out_data`, `out_count` and `out_overflow` are stable while `out_valid && !out_ready`.
- **Upstream rule:** upstream holds `in_carry`/`in_sum` stable while `in_valid && !in_ready`. The block samples them only on accept.

## Test plan
All scenarios use BLOCK_LEN=4, ACC_WIDTH=16 unless stated.
- **Full block:** beats 0x0FF, 0x100, 0x001, 0x1FF on consecutive cycles, `out_ready`=1 → `out_data`=0x03FF, `out_count`=4, `out_overflow`=0. `out_valid` is high exactly one cycle, the cycle after the 4th accept. `in_ready` is low that cycle, then 1.
- **Backpressure:** as above but `out_ready`=0 for 5 cycles, `in_valid` held high with 0x007 → `in_ready`=0 and outputs frozen for those 5 cycles. After the handshake, the next four 0x007 beats yield 0x001C.
- **Flush:**
  - beats 0x010, 0x020, then `flush` alone → 0x0030, count 2;
  - `flush` in the same cycle as beat 0x005 after 0x010, 0x020 → 0x0035, count 3;
  - `flush` at cnt 0 → no `out_valid`.
- **Overflow:** ACC_WIDTH=9, beats 0x1FF, 0x1FF, then `flush` → `out_data`=0x1FE, count 2, `out_overflow`=1. The next block of four 0x001 → 0x004, overflow 0.
- **Reset mid-block:** accept 3 beats of 0x0AA, pulse `rst_n` low for half a cycle → all outputs return to reset values immediately. Then four 0x001 beats → 0x0004, count 4.
- **Reset during HOLD:** assert `rst_n` with `out_valid`=1 → `out_valid` drops immediately, `in_ready`=1, and the pending result is never presented.
